// File: rtl/safe_obi_lockstep_bridge.sv
// Redundancy bridge between NHARTS OBI cores and the system bus.
// Independent mode passes every channel straight through. DMR/TMR mode aligns
// the participating requests inside a skew window. It then compares or
// majority-votes them and issues a single request on channel 0. The single
// response is fanned back out to the participating harts. The bridge also
// reports skew timeouts and dissenting harts, and keeps a saturating error count.

package safe_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    MODE_INDEP = 2'd0,
    MODE_DMR   = 2'd1,
    MODE_TMR   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

endpackage

module safe_obi_lockstep_bridge
  import safe_obi_pkg::*;
#(
  parameter int NHARTS    = 3,
  parameter int SKEW_MAX  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                mode_i,
  input  obi_req_t  [NHARTS-1:0]    core_req_i,
  output obi_resp_t [NHARTS-1:0]    core_resp_o,
  output obi_req_t  [NHARTS-1:0]    bus_req_o,
  input  obi_resp_t [NHARTS-1:0]    bus_resp_i,
  input  logic                      err_clr_i,
  output logic                      mismatch_o,
  output logic [NHARTS-1:0]         mismatch_id_o,
  output logic                      timeout_o,
  output logic [ERR_CNT_W-1:0]      err_cnt_o
);

  localparam int SKEW_W = (SKEW_MAX < 2) ? 1 : $clog2(SKEW_MAX + 1);
  // Third voter; folds onto hart 0 when there are only two harts (TMR then acts as DMR).
  localparam int H2     = (NHARTS >= 3) ? 2 : 0;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_RESP, S_ERROR} state_e;

  state_e                r_state, w_state_next;
  mode_e                 r_mode_q;
  logic [SKEW_W-1:0]     r_skew_cnt;
  obi_req_t              r_voted_q;
  logic                  r_mismatch;
  logic [NHARTS-1:0]     r_mismatch_id;
  logic                  r_timeout;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic                  w_redundant, w_tmr, w_all, w_any;
  logic [NHARTS-1:0]     w_pmask, w_req_vec, w_mm_id;
  obi_req_t              w_h0, w_h1, w_h2, w_voted;
  logic                  w_capture, w_timeout_evt, w_mm_evt;

  // Decode the latched mode into the participating set and the set of pending requests.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_redundant = (r_mode_q == MODE_DMR) || (r_mode_q == MODE_TMR);
    w_tmr       = (r_mode_q == MODE_TMR) && (NHARTS >= 3);
    w_pmask     = '0;
    w_req_vec   = '0;
    for (int i = 0; i < NHARTS; i++) begin
      w_pmask[i]   = w_redundant && ((i < 2) || (w_tmr && (i == 2)));
      w_req_vec[i] = core_req_i[i].req;
    end
    w_all = w_redundant && ((w_req_vec & w_pmask) == w_pmask);
    w_any = |(w_req_vec & w_pmask);
  end

  // Vote (TMR) or compare (DMR) the payload fields and identify the dissenters.
  always_comb begin
    w_h0     = core_req_i[0];
    w_h0.req = 1'b0;
    w_h1     = core_req_i[1];
    w_h1.req = 1'b0;
    w_h2     = core_req_i[H2];
    w_h2.req = 1'b0;
    w_mm_id  = '0;
    if (w_tmr) begin
      w_voted     = (w_h0 & w_h1) | (w_h0 & w_h2) | (w_h1 & w_h2);
      w_mm_id[0]  = (w_h0 != w_voted);
      w_mm_id[1]  = (w_h1 != w_voted);
      w_mm_id[H2] = (w_h2 != w_voted);
    end else begin
      w_voted = w_h0;
      if (w_h0 != w_h1) w_mm_id[1:0] = 2'b11;
    end
  end

  // Transaction sequencing: align, issue once, wait for the response, or trap in ERROR.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        // Wait until the latched mode agrees with mode_i, so a mode change never starts a stale transaction.
        if (w_redundant && (mode_e'(mode_i) == r_mode_q)) begin
          if (w_all)      w_state_next = S_ISSUE;
          else if (w_any) w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_all)                                      w_state_next = S_ISSUE;
        else if (r_skew_cnt == SKEW_W'(SKEW_MAX - 1))   w_state_next = S_ERROR;
      end
      S_ISSUE: if (bus_resp_i[0].gnt)    w_state_next = S_RESP;
      S_RESP:  if (bus_resp_i[0].rvalid) w_state_next = S_IDLE;
      S_ERROR: begin
        if (err_clr_i || (mode_i == MODE_INDEP) || (mode_i == MODE_RSVD)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_capture     = (w_state_next == S_ISSUE) && (r_state != S_ISSUE);
  assign w_timeout_evt = (r_state == S_COLLECT) && (w_state_next == S_ERROR);
  assign w_mm_evt      = w_capture && (|w_mm_id);

  // FSM state, latched mode, skew counter and the captured voted request.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_mode_q   <= MODE_INDEP;
      r_skew_cnt <= '0;
      r_voted_q  <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && (w_state_next == S_IDLE)) r_mode_q <= mode_e'(mode_i);
      if (r_state == S_IDLE)          r_skew_cnt <= '0;
      else if (r_state == S_COLLECT)  r_skew_cnt <= r_skew_cnt + SKEW_W'(1);
      if (w_capture) r_voted_q <= w_voted;
    end
  end

  // Mismatch pulse, sticky timeout and saturating error counter; a clear beats an increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mismatch    <= 1'b0;
      r_mismatch_id <= '0;
      r_timeout     <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_mismatch    <= w_mm_evt;
      r_mismatch_id <= w_mm_evt ? w_mm_id : '0;
      if (err_clr_i) begin
        r_timeout <= 1'b0;
        r_err_cnt <= '0;
      end else begin
        if (w_timeout_evt) r_timeout <= 1'b1;
        if ((w_mm_evt || w_timeout_evt) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  // Route requests and responses: pass-through, or channel 0 fanned out to the participating harts.
  always_comb begin
    bus_req_o   = '0;
    core_resp_o = '0;
    if (!w_redundant) begin
      bus_req_o   = core_req_i;
      core_resp_o = bus_resp_i;
    end else begin
      unique case (r_state)
        S_ISSUE: begin
          bus_req_o[0]     = r_voted_q;
          bus_req_o[0].req = 1'b1;
          for (int i = 0; i < NHARTS; i++)
            if (w_pmask[i]) core_resp_o[i].gnt = bus_resp_i[0].gnt;
        end
        S_RESP: begin
          for (int i = 0; i < NHARTS; i++) begin
            if (w_pmask[i]) begin
              core_resp_o[i].rvalid = bus_resp_i[0].rvalid;
              core_resp_o[i].rdata  = bus_resp_i[0].rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mismatch_o    = r_mismatch;
  assign mismatch_id_o = r_mismatch_id;
  assign timeout_o     = r_timeout;
  assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_safe_obi_lockstep_bridge.sv
// Scoreboard bench for safe_obi_lockstep_bridge.
// Stimulus tasks push the expected bus requests, responses and mismatch reports into queues.
// A negedge monitor pops and compares them whenever the DUT presents a handshake.
module tb_safe_obi_lockstep_bridge;
  import safe_obi_pkg::*;

  localparam int N    = 3;
  localparam int SKEW = 4;
  localparam int EW   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           mode;
  obi_req_t  [N-1:0]    core_req;
  obi_resp_t [N-1:0]    core_resp;
  obi_req_t  [N-1:0]    bus_req;
  obi_resp_t [N-1:0]    bus_resp;
  logic                 err_clr;
  logic                 mm;
  logic [N-1:0]         mm_id;
  logic                 tmo;
  logic [EW-1:0]        err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int model_err   = 0;

  obi_req_t     bus_exp_q  [N][$];
  logic [31:0]  resp_exp_q [N][$];
  logic [N-1:0] mm_exp_q   [$];

  safe_obi_lockstep_bridge #(.NHARTS(N), .SKEW_MAX(SKEW), .ERR_CNT_W(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
    .core_req_i(core_req), .core_resp_o(core_resp),
    .bus_req_o(bus_req), .bus_resp_i(bus_resp),
    .err_clr_i(err_clr), .mismatch_o(mm), .mismatch_id_o(mm_id),
    .timeout_o(tmo), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int ch);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected DUT event on hart/channel %0d at %0t", name, ch, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obi_req_t rand_req();
    obi_req_t r;
    r.req   = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.be    = 4'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  // Bitwise 2-of-3 by counting ones per bit position.
  function automatic obi_req_t vote3(input obi_req_t a, input obi_req_t b, input obi_req_t c);
    logic [$bits(obi_req_t)-1:0] va, vb, vc, vr;
    obi_req_t r;
    va = a; vb = b; vc = c;
    for (int i = 0; i < $bits(obi_req_t); i++) begin
      int ones;
      ones  = int'(va[i]) + int'(vb[i]) + int'(vc[i]);
      vr[i] = (ones >= 2);
    end
    r     = vr;
    r.req = 1'b1;
    return r;
  endfunction

  function automatic bit same_payload(input obi_req_t a, input obi_req_t b);
    a.req = 1'b0;
    b.req = 1'b0;
    return a == b;
  endfunction

  function automatic obi_req_t flip_bit(input obi_req_t r);
    logic [$bits(obi_req_t)-1:0] v;
    v = r;
    v[$urandom_range(0, $bits(obi_req_t) - 2)] ^= 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] gnts();
    logic [N-1:0] g;
    for (int h = 0; h < N; h++) g[h] = core_resp[h].gnt;
    return g;
  endfunction

  function automatic logic [N-1:0] rvalids();
    logic [N-1:0] v;
    for (int h = 0; h < N; h++) v[h] = core_resp[h].rvalid;
    return v;
  endfunction

  // Scoreboard monitor: compare every bus handshake, core rvalid and mismatch pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < N; c++) begin
        if (bus_req[c].req && bus_resp[c].gnt) begin
          if (bus_exp_q[c].size() == 0) unexpected("bus_handshake", c);
          else check("bus_req_payload", bus_req[c], bus_exp_q[c].pop_front());
        end
        if (core_resp[c].rvalid) begin
          if (resp_exp_q[c].size() == 0) unexpected("core_rvalid", c);
          else check("core_rdata", core_resp[c].rdata, resp_exp_q[c].pop_front());
        end
      end
      if (mm) begin
        if (mm_exp_q.size() == 0) unexpected("mismatch_pulse", 0);
        else check("mismatch_id", mm_id, mm_exp_q.pop_front());
      end
    end
  end

  task automatic go_mode(input logic [1:0] m);
    mode = m;
    step();
    step();
  endtask

  // Three concurrent pass-through transactions, one per channel.
  task automatic indep_round();
    for (int h = 0; h < N; h++) begin
      core_req[h]     = rand_req();
      bus_resp[h].gnt = 1'b1;
      bus_exp_q[h].push_back(core_req[h]);
    end
    #1;
    for (int h = 0; h < N; h++) check("passthru_req", bus_req[h], core_req[h]);
    check("passthru_gnt", gnts(), 3'b111);
    step();
    for (int h = 0; h < N; h++) begin
      core_req[h]        = '0;
      bus_resp[h].gnt    = 1'b0;
      bus_resp[h].rvalid = 1'b1;
      bus_resp[h].rdata  = $urandom;
      resp_exp_q[h].push_back(bus_resp[h].rdata);
    end
    step();
    bus_resp = '0;
    check("indep_err_cnt", err_cnt, model_err);
  endtask

  // One redundant transaction; hart 0 asserts at offset 0, harts 1/2 at d1/d2.
  task automatic red_txn(input logic [1:0] md, input obi_req_t q0, input obi_req_t q1,
                         input obi_req_t q2, input int d1, input int d2, input int gdly,
                         input int rdly, input bit sw);
    obi_req_t     q [3];
    int           dl [3];
    int           np, maxd;
    obi_req_t     exp_r;
    logic [N-1:0] ids, pm;
    logic [31:0]  rd;
    q[0] = q0; q[1] = q1; q[2] = q2;
    for (int h = 0; h < 3; h++) q[h].req = 1'b1;
    dl[0] = 0; dl[1] = d1; dl[2] = d2;
    np  = (md == 2'd2) ? 3 : 2;
    pm  = (np == 3) ? 3'b111 : 3'b011;
    ids = '0;
    if (np == 3) begin
      exp_r = vote3(q[0], q[1], q[2]);
      for (int h = 0; h < 3; h++) ids[h] = !same_payload(q[h], exp_r);
    end else begin
      exp_r     = q[0];
      exp_r.req = 1'b1;
      if (!same_payload(q[0], q[1])) ids = 3'b011;
    end
    maxd = dl[1];
    if (np == 3 && dl[2] > maxd) maxd = dl[2];
    bus_exp_q[0].push_back(exp_r);
    if (ids != '0) begin
      mm_exp_q.push_back(ids);
      if (model_err < 255) model_err++;
    end
    for (int c = 0; c <= maxd; c++) begin
      for (int h = 0; h < np; h++) if (c == dl[h]) core_req[h] = q[h];
      if (np == 2 && c == 0) core_req[2] = rand_req();
      #1;
      check("no_early_issue", bus_req[0].req, 1'b0);
      step();
    end
    check("issue_latency", bus_req[0].req, 1'b1);
    check("side_channels_idle", {bus_req[2].req, bus_req[1].req}, 2'b00);
    for (int g = 0; g < gdly; g++) begin
      check("gnt_held_back", gnts(), 3'b000);
      step();
    end
    bus_resp[0].gnt = 1'b1;
    #1;
    check("gnt_fanout", gnts(), pm);
    step();
    core_req        = '0;
    bus_resp[0].gnt = 1'b0;
    if (sw) mode = 2'd0;
    for (int r = 0; r < rdly; r++) begin
      check("rvalid_held_back", rvalids(), 3'b000);
      step();
    end
    rd                    = $urandom;
    bus_resp[0].rvalid    = 1'b1;
    bus_resp[0].rdata     = rd;
    for (int h = 0; h < np; h++) resp_exp_q[h].push_back(rd);
    step();
    bus_resp[0] = '0;
    check("err_cnt", err_cnt, model_err);
    check("no_timeout", tmo, 1'b0);
  endtask

  // DMR with hart 1 never arriving: timeout boundary, no grant, then clear.
  task automatic timeout_test();
    core_req[0] = rand_req();
    step();
    for (int k = 1; k <= 3; k++) step();
    check("timeout_not_yet_t4", tmo, 1'b0);
    step();
    check("timeout_set_t5", tmo, 1'b1);
    if (model_err < 255) model_err++;
    check("timeout_err_cnt", err_cnt, model_err);
    bus_resp[0].gnt = 1'b1;
    #1;
    check("error_no_gnt", gnts(), 3'b000);
    check("error_no_bus_req", bus_req[0].req, 1'b0);
    step();
    step();
    check("timeout_sticky", tmo, 1'b1);
    core_req        = '0;
    bus_resp[0].gnt = 1'b0;
    err_clr         = 1'b1;
    step();
    err_clr   = 1'b0;
    model_err = 0;
    check("clear_timeout", tmo, 1'b0);
    check("clear_err_cnt", err_cnt, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obi_req_t a, b, c;
    rst_n    = 1'b0;
    mode     = 2'd0;
    err_clr  = 1'b0;
    core_req = '0;
    bus_resp = '0;
    step();
    step();
    check("rst_mismatch", mm, 1'b0);
    check("rst_mismatch_id", mm_id, 3'b000);
    check("rst_timeout", tmo, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    core_req[1] = rand_req();
    #1;
    check("rst_passthru", bus_req[1], core_req[1]);
    core_req = '0;
    rst_n    = 1'b1;
    step();

    for (int i = 0; i < 3; i++) indep_round();

    go_mode(2'd2);
    a = '0; a.we = 1'b1; a.be = 4'hF; a.addr = 32'h1000; a.wdata = 32'hDEADBEEF;
    red_txn(2'd2, a, a, a, 0, 0, 0, 0, 1'b0);
    b = a; b.wdata = 32'hDEADBEEE;
    red_txn(2'd2, a, a, b, 0, 0, 1, 2, 1'b0);
    check("single_mismatch_cnt", err_cnt, 8'd1);
    red_txn(2'd2, a, a, a, 2, 4, 0, 0, 1'b0);

    go_mode(2'd1);
    a = rand_req();
    red_txn(2'd1, a, a, a, 3, 0, 0, 1, 1'b0);
    timeout_test();
    red_txn(2'd1, a, flip_bit(a), a, 0, 0, 0, 0, 1'b0);

    go_mode(2'd2);
    red_txn(2'd2, a, a, a, 1, 0, 0, 0, 1'b1);
    step();
    indep_round();

    for (int i = 0; i < 40; i++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd1;
      go_mode(md);
      a = rand_req();
      b = ($urandom_range(0, 3) == 0) ? flip_bit(a) : a;
      c = ($urandom_range(0, 3) == 0) ? flip_bit(a) : a;
      red_txn(md, ($urandom_range(0, 5) == 0) ? flip_bit(a) : a, b, c,
              $urandom_range(0, SKEW), $urandom_range(0, SKEW),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    go_mode(2'd1);
    for (int i = 0; i < 256; i++) begin
      a = rand_req();
      b = a;
      b.wdata = ~a.wdata;
      red_txn(2'd1, a, b, a, 0, 0, 0, 0, 1'b0);
    end
    check("err_cnt_saturated", err_cnt, 8'hFF);

    go_mode(2'd2);
    a = rand_req();
    core_req[0] = a; core_req[1] = a; core_req[2] = a;
    step();
    check("pre_reset_issue", bus_req[0].req, 1'b1);
    core_req = '0;
    rst_n    = 1'b0;
    step();
    rst_n     = 1'b1;
    model_err = 0;
    check("reset_drops_req", bus_req[0].req, 1'b0);
    check("reset_err_cnt", err_cnt, 8'd0);
    core_req[2] = rand_req();
    #1;
    check("post_reset_passthru", bus_req[2], core_req[2]);
    core_req = '0;
    step();
    step();

    for (int ch = 0; ch < N; ch++) begin
      check("bus_queue_drained", bus_exp_q[ch].size(), 0);
      check("resp_queue_drained", resp_exp_q[ch].size(), 0);
    end
    check("mismatch_queue_drained", mm_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
